// File: rtl/score_digits_renderer.sv
// score_digits_renderer
//   Converts a binary score to BCD with a multi-cycle double-dabble FSM, holds
//   the committed digits, and for every pixel reports whether it falls inside
//   a visible digit cell. It also reports the digit value and the offsets
//   inside the glyph, so the downstream bitmap stage can look up the glyph bit.
//   Digits are placed left to right, most significant first, from
//   (topLeftX, topLeftY).
//
// Ports
//   clk           in   pixel clock
//   resetN        in   async reset, active-low
//   startOfFrame  in   1-cycle pulse in vertical blank, starts a conversion
//   score         in   unsigned binary score (saturated to 10^NUM_DIGITS-1)
//   pixelX/Y      in   current pixel column / row
//   topLeftX/Y    in   top-left corner of the digit field
//   in_container  out  pixel inside a visible (non-blanked) digit cell
//   digit         out  BCD value of the cell under the pixel
//   offsetX/Y     out  position inside the cell
//   busy          out  conversion in progress
//
// FSM states
//   state     | meaning
//   S_IDLE    | waiting for startOfFrame
//   S_LOAD    | sample and saturate score, clear BCD field and counter
//   S_SHIFT   | SCORE_W double-dabble iterations (adjust, then shift left)
//   S_COMMIT  | copy BCD nibbles to the committed digit registers
module score_digits_renderer #(
    parameter int NUM_DIGITS      = 4,
    parameter int SCORE_W         = 14,
    parameter int DIGIT_W         = 16,
    parameter int DIGIT_H         = 32,
    parameter int LEAD_ZERO_BLANK = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [SCORE_W-1:0] score,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic [10:0]        topLeftX,
    input  logic [10:0]        topLeftY,
    output logic               in_container,
    output logic [3:0]         digit,
    output logic [10:0]        offsetX,
    output logic [10:0]        offsetY,
    output logic               busy
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int DD_W  = BCD_W + SCORE_W;
    localparam int LOG_W = $clog2(DIGIT_W);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(10 ** NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(SCORE_W - 1);
    localparam logic [11:0]        FIELD_W   = 12'(NUM_DIGITS * DIGIT_W);
    localparam logic [11:0]        CELL_H    = 12'(DIGIT_H);
    localparam logic [10:0]        OFS_MASK  = 11'(DIGIT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t           state;
    logic [DD_W-1:0]  dd_q;
    logic [DD_W-1:0]  dd_adj;
    logic [CNT_W-1:0] iter;
    logic [3:0]       digits_q [NUM_DIGITS];

    // ---------------------------------------------------------------
    // Double-dabble adjust: every BCD nibble >= 5 gets +3 before the shift
    // ---------------------------------------------------------------
    always_comb begin
        dd_adj = dd_q;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (dd_q[SCORE_W + 4*n +: 4] >= 4'd5)
                dd_adj[SCORE_W + 4*n +: 4] = dd_q[SCORE_W + 4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            dd_q  <= '0;
            iter  <= '0;
            for (int n = 0; n < NUM_DIGITS; n++)
                digits_q[n] <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (startOfFrame) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dd_q  <= {BCD_W'(0), (score > MAX_SCORE) ? MAX_SCORE : score};
                    iter  <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    dd_q <= dd_adj << 1;
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER)
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    // Index 0 is the most significant digit, which sits in the top nibble.
                    for (int n = 0; n < NUM_DIGITS; n++)
                        digits_q[n] <= dd_q[SCORE_W + 4*(NUM_DIGITS-1-n) +: 4];
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Leading-zero blanking from the committed digits only
    // ---------------------------------------------------------------
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (digits_q[i] == 4'd0);
            if ((LEAD_ZERO_BLANK != 0) && (i < NUM_DIGITS - 1))
                blank[i] = zero_run;
        end
    end

    // ---------------------------------------------------------------
    // Pixel path; 12-bit differences so a pixel left/above the field is not
    // mistaken for one inside it after wrap.
    // ---------------------------------------------------------------
    logic [11:0]      rel_x;
    logic [11:0]      rel_y;
    logic             in_field;
    logic [IDX_W-1:0] idx;

    assign rel_x    = {1'b0, pixelX} - {1'b0, topLeftX};
    assign rel_y    = {1'b0, pixelY} - {1'b0, topLeftY};
    assign in_field = (pixelX >= topLeftX) && (pixelY >= topLeftY) &&
                      (rel_x < FIELD_W) && (rel_y < CELL_H);
    assign idx      = rel_x[LOG_W +: IDX_W];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            in_container <= 1'b0;
            digit        <= 4'd0;
            offsetX      <= 11'd0;
            offsetY      <= 11'd0;
        end else if (in_field) begin
            in_container <= ~blank[idx];
            digit        <= digits_q[idx];
            offsetX      <= rel_x[10:0] & OFS_MASK;
            offsetY      <= rel_y[10:0];
        end else begin
            in_container <= 1'b0;
            digit        <= 4'd0;
            offsetX      <= 11'd0;
            offsetY      <= 11'd0;
        end
    end

endmodule

// File: tb/tb_score_digits_renderer.sv
module tb_score_digits_renderer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [13:0] score = '0;
    logic [10:0] pixelX = '0, pixelY = '0, topLeftX = '0, topLeftY = '0;

    logic        in_container, busy;
    logic [3:0]  digit;
    logic [10:0] offsetX, offsetY;
    logic        nb_in_container, nb_busy;
    logic [3:0]  nb_digit;
    logic [10:0] nb_offsetX, nb_offsetY;

    score_digits_renderer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .score(score),
        .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .in_container(in_container), .digit(digit), .offsetX(offsetX),
        .offsetY(offsetY), .busy(busy)
    );

    score_digits_renderer #(.LEAD_ZERO_BLANK(0)) dut_nb (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .score(score),
        .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .in_container(nb_in_container), .digit(nb_digit), .offsetX(nb_offsetX),
        .offsetY(nb_offsetY), .busy(nb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inc;
        logic [3:0]  d;
        logic [10:0] ox;
        logic [10:0] oy;
    } exp_t;

    exp_t q_b[$];
    exp_t q_n[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tlx = 100;
    int   tly = 50;
    int   m_dig[4] = '{0, 0, 0, 0};

    function automatic exp_t model_px(input int x, input int y, input bit lzb);
        exp_t e;
        int   rx = x - tlx;
        int   ry = y - tly;
        int   ix;
        bit   zr = 1'b1;
        e.inc = 1'b0; e.d = 4'd0; e.ox = 11'd0; e.oy = 11'd0;
        if (rx >= 0 && ry >= 0 && rx < 64 && ry < 32) begin
            ix = rx / 16;
            for (int k = 0; k <= ix; k++)
                if (m_dig[k] != 0) zr = 1'b0;
            e.inc = !(lzb && ix < 3 && zr);
            e.d   = 4'(m_dig[ix]);
            e.ox  = 11'(rx % 16);
            e.oy  = 11'(ry);
        end
        return e;
    endfunction

    task automatic set_model(input int s);
        int sat = (s > 9999) ? 9999 : s;
        m_dig[0] = sat / 1000;
        m_dig[1] = (sat / 100) % 10;
        m_dig[2] = (sat / 10) % 10;
        m_dig[3] = sat % 10;
    endtask

    // drive one pixel and queue the expected outputs of both instances
    task automatic drive_px(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        q_b.push_back(model_px(x, y, 1'b1));
        q_n.push_back(model_px(x, y, 1'b0));
    endtask

    task automatic test_reset();
        int   xs[3] = '{103, 151, 120};
        exp_t eb, en;
        resetN = 1'b0;
        topLeftX = 11'(tlx); topLeftY = 11'(tly);
        pixelX = 11'(tlx + 3); pixelY = 11'(tly + 5);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_container, digit, offsetX, offsetY, busy} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_hold got in=%b d=%0d ox=%0d oy=%0d busy=%b required all 0",
                     in_container, digit, offsetX, offsetY, busy);
        end
        resetN = 1'b1;
        #1;
        n_checks++;
        if ({in_container, digit, offsetX, offsetY, busy, nb_in_container, nb_busy} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_release got in=%b d=%0d busy=%b nb_in=%b required all 0",
                     in_container, digit, busy, nb_in_container);
        end
        for (int i = 0; i < 3; i++) begin
            drive_px(xs[i], tly + 5);
            @(posedge clk); #1;
            eb = q_b.pop_front(); en = q_n.pop_front();
            n_checks++;
            if ({in_container, digit, offsetX, offsetY} !== {eb.inc, eb.d, eb.ox, eb.oy}) begin
                n_fail++;
                $display("FAIL reset_px x=%0d got in=%b d=%0d ox=%0d oy=%0d required in=%b d=%0d ox=%0d oy=%0d",
                         xs[i], in_container, digit, offsetX, offsetY, eb.inc, eb.d, eb.ox, eb.oy);
            end
            n_checks++;
            if ({nb_in_container, nb_digit, nb_offsetX, nb_offsetY} !== {en.inc, en.d, en.ox, en.oy}) begin
                n_fail++;
                $display("FAIL reset_px_nb x=%0d got in=%b d=%0d required in=%b d=%0d",
                         xs[i], nb_in_container, nb_digit, en.inc, en.d);
            end
        end
    endtask

    task automatic test_score(input int s);
        int   cnt;
        exp_t eb, en;
        score = 14'(s);
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL busy_len score=%0d got %0d cycles required 16", s, cnt);
        end
        set_model(s);
        for (int i = 0; i < 4; i++) begin
            drive_px(tlx + i*16 + 5, tly + 10);
            @(posedge clk); #1;
            eb = q_b.pop_front(); en = q_n.pop_front();
            n_checks++;
            if ({in_container, digit, offsetX, offsetY} !== {eb.inc, eb.d, eb.ox, eb.oy}) begin
                n_fail++;
                $display("FAIL score_px score=%0d idx=%0d got in=%b d=%0d ox=%0d oy=%0d required in=%b d=%0d ox=%0d oy=%0d",
                         s, i, in_container, digit, offsetX, offsetY, eb.inc, eb.d, eb.ox, eb.oy);
            end
            n_checks++;
            if ({nb_in_container, nb_digit, nb_offsetX, nb_offsetY} !== {en.inc, en.d, en.ox, en.oy}) begin
                n_fail++;
                $display("FAIL score_px_nb score=%0d idx=%0d got in=%b d=%0d required in=%b d=%0d",
                         s, i, nb_in_container, nb_digit, en.inc, en.d);
            end
        end
    endtask

    task automatic test_ignore_restart();
        int   cnt;
        exp_t eb;
        score = 14'd2468;
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        score = 14'd5678;
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        cnt = 5;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL restart_busy_len got %0d cycles required 16", cnt);
        end
        set_model(2468);
        for (int i = 0; i < 4; i++) begin
            drive_px(tlx + i*16 + 7, tly + 20);
            @(posedge clk); #1;
            eb = q_b.pop_front(); void'(q_n.pop_front());
            n_checks++;
            if ({in_container, digit, offsetX, offsetY} !== {eb.inc, eb.d, eb.ox, eb.oy}) begin
                n_fail++;
                $display("FAIL restart_px idx=%0d got in=%b d=%0d ox=%0d oy=%0d required in=%b d=%0d ox=%0d oy=%0d",
                         i, in_container, digit, offsetX, offsetY, eb.inc, eb.d, eb.ox, eb.oy);
            end
        end
        // a second conversion must be accepted once back in IDLE
        test_score(5678);
    endtask

    task automatic test_reset_mid();
        int   xs[2] = '{105, 150};
        exp_t eb, en;
        pixelX = 11'(tlx + 5); pixelY = 11'(tly + 5);
        score = 14'd1357;
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_container, digit, nb_busy, nb_digit} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b in=%b d=%0d nb_busy=%b nb_d=%0d required all 0",
                     busy, in_container, digit, nb_busy, nb_digit);
        end
        #3;
        resetN = 1'b1;
        set_model(0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort got busy=%b required 0", busy);
        end
        for (int i = 0; i < 2; i++) begin
            drive_px(xs[i], tly + 12);
            @(posedge clk); #1;
            eb = q_b.pop_front(); en = q_n.pop_front();
            n_checks++;
            if ({in_container, digit, offsetX, offsetY} !== {eb.inc, eb.d, eb.ox, eb.oy}) begin
                n_fail++;
                $display("FAIL reset_mid_px x=%0d got in=%b d=%0d ox=%0d oy=%0d required in=%b d=%0d ox=%0d oy=%0d",
                         xs[i], in_container, digit, offsetX, offsetY, eb.inc, eb.d, eb.ox, eb.oy);
            end
            n_checks++;
            if ({nb_in_container, nb_digit} !== {en.inc, en.d}) begin
                n_fail++;
                $display("FAIL reset_mid_px_nb x=%0d got in=%b d=%0d required in=%b d=%0d",
                         xs[i], nb_in_container, nb_digit, en.inc, en.d);
            end
        end
    endtask

    task automatic test_boundary();
        int   xs[9] = '{99, 100, 163, 164, 110, 110, 110, 110, 0};
        int   ys[9] = '{60, 60, 60, 60, 50, 81, 82, 49, 60};
        exp_t eb, en;
        test_score(1234);
        for (int i = 0; i < 9; i++) begin
            drive_px(xs[i], ys[i]);
            @(posedge clk); #1;
            eb = q_b.pop_front(); en = q_n.pop_front();
            n_checks++;
            if ({in_container, digit, offsetX, offsetY} !== {eb.inc, eb.d, eb.ox, eb.oy}) begin
                n_fail++;
                $display("FAIL boundary x=%0d y=%0d got in=%b d=%0d ox=%0d oy=%0d required in=%b d=%0d ox=%0d oy=%0d",
                         xs[i], ys[i], in_container, digit, offsetX, offsetY, eb.inc, eb.d, eb.ox, eb.oy);
            end
            n_checks++;
            if ({nb_in_container, nb_digit, nb_offsetX, nb_offsetY} !== {en.inc, en.d, en.ox, en.oy}) begin
                n_fail++;
                $display("FAIL boundary_nb x=%0d y=%0d got in=%b d=%0d required in=%b d=%0d",
                         xs[i], ys[i], nb_in_container, nb_digit, en.inc, en.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_score(1234);
        test_score(12000);
        test_score(9999);
        test_score(0);
        test_score(42);
        test_score(305);
        test_ignore_restart();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
